// File: rtl/dpic_sram_arbiter.sv
// ---------------------------------------------------------------------------
// dpic_sram_arbiter
//
// Purpose:
//   Shares one single-cycle DPI-C SRAM port between two requesters.
//   Port 0 is instruction fetch and port 1 is load/store. Each port has a
//   valid/ready request channel and a valid/ready response channel. Each port
//   also has a one-entry registered response buffer. Arbitration is
//   round-robin by default.
//
// Configuration macro:
//   DPIC_SRAM_ARB_FIXED_PRIO_EN - when defined, port 1 always wins a conflict
//                                 and the priority pointer register is removed.
//
// Ports (index [p] selects port 0 or port 1):
//   i_clk           clock
//   i_rst           synchronous, active-high reset
//   i_req_valid[p]  request valid
//   i_req_addr[p]   request byte address
//   i_req_wmask[p]  byte write mask, 0 = read
//   i_req_size[p]   access size, log2 of bytes
//   i_req_wdata[p]  write data
//   o_req_ready[p]  request accepted this cycle (the grant)
//   o_resp_valid[p] response held in buffer
//   o_resp_rdata[p] response data, 0 for writes
//   i_resp_ready[p] consumer takes the response
//   o_sram_*        muxed SRAM access of the winning port
//   i_sram_rdata    SRAM read data, combinational in the access cycle
// ---------------------------------------------------------------------------
module dpic_sram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [1:0]                           i_req_valid,
    input  logic [1:0][ADDR_WIDTH-1:0]           i_req_addr,
    input  logic [1:0][DATA_WIDTH/8-1:0]         i_req_wmask,
    input  logic [1:0][1:0]                      i_req_size,
    input  logic [1:0][DATA_WIDTH-1:0]           i_req_wdata,
    output logic [1:0]                           o_req_ready,
    output logic [1:0]                           o_resp_valid,
    output logic [1:0][DATA_WIDTH-1:0]           o_resp_rdata,
    input  logic [1:0]                           i_resp_ready,
    output logic                                 o_sram_en,
    output logic [ADDR_WIDTH-1:0]                o_sram_addr,
    output logic [DATA_WIDTH/8-1:0]              o_sram_wmask,
    output logic [1:0]                           o_sram_size,
    output logic [DATA_WIDTH-1:0]                o_sram_wdata,
    input  logic [DATA_WIDTH-1:0]                i_sram_rdata
);

    logic [1:0]                 r_resp_valid;
    logic [1:0][DATA_WIDTH-1:0] r_resp_rdata;
    logic [1:0]                 w_slot_free;
    logic [1:0]                 w_elig;
    logic [1:0]                 w_grant;
    logic                       w_sel;

`ifndef DPIC_SRAM_ARB_FIXED_PRIO_EN
    // Priority pointer: names the port that wins the next conflict.
    logic                       r_ptr;
`endif

    // A buffer can accept a new response if it is empty or drains this cycle;
    // nothing is eligible while reset is asserted.
    always_comb begin
        w_slot_free = ~r_resp_valid | i_resp_ready;
        if (i_rst) begin
            w_elig = 2'b00;
        end else begin
            w_elig = i_req_valid & w_slot_free;
        end
    end

    // Grant selection: single eligible port wins, conflicts resolved by policy.
    always_comb begin
        w_grant = 2'b00;
        case (w_elig)
            2'b01: w_grant = 2'b01;
            2'b10: w_grant = 2'b10;
            2'b11: begin
`ifdef DPIC_SRAM_ARB_FIXED_PRIO_EN
                w_grant = 2'b10;
`else
                if (r_ptr) begin
                    w_grant = 2'b10;
                end else begin
                    w_grant = 2'b01;
                end
`endif
            end
            default: w_grant = 2'b00;
        endcase
    end

    // Mux the winning request onto the SRAM port; idle bus is driven to zero.
    always_comb begin
        w_sel        = w_grant[1];
        o_req_ready  = w_grant;
        o_sram_en    = |w_grant;
        if (|w_grant) begin
            o_sram_addr  = i_req_addr[w_sel];
            o_sram_wmask = i_req_wmask[w_sel];
            o_sram_size  = i_req_size[w_sel];
            o_sram_wdata = i_req_wdata[w_sel];
        end else begin
            o_sram_addr  = '0;
            o_sram_wmask = '0;
            o_sram_size  = 2'b00;
            o_sram_wdata = '0;
        end
    end

    // Response buffers: load on grant (reads capture SRAM data, writes ack
    // with zero), clear on consume, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp_valid <= 2'b00;
            r_resp_rdata <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_grant[p]) begin
                    r_resp_valid[p] <= 1'b1;
                    if (|i_req_wmask[p]) begin
                        r_resp_rdata[p] <= '0;
                    end else begin
                        r_resp_rdata[p] <= i_sram_rdata;
                    end
                end else if (r_resp_valid[p] && i_resp_ready[p]) begin
                    r_resp_valid[p] <= 1'b0;
                end else begin
                    r_resp_valid[p] <= r_resp_valid[p];
                end
            end
        end
    end

`ifndef DPIC_SRAM_ARB_FIXED_PRIO_EN
    // Round-robin pointer: after a grant, the other port gets priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (|w_grant) begin
            r_ptr <= w_grant[0];
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dpic_sram_arbiter.sv
// Directed self-checking bench for dpic_sram_arbiter with a small SRAM model.
module tb_dpic_sram_arbiter;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_addr;
    logic [1:0][3:0]  req_wmask;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       resp_ready;
    logic             sram_en;
    logic [31:0]      sram_addr;
    logic [3:0]       sram_wmask;
    logic [1:0]       sram_size;
    logic [31:0]      sram_wdata;
    logic [31:0]      sram_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:15];

    dpic_sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_addr   (req_addr),
        .i_req_wmask  (req_wmask),
        .i_req_size   (req_size),
        .i_req_wdata  (req_wdata),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .i_resp_ready (resp_ready),
        .o_sram_en    (sram_en),
        .o_sram_addr  (sram_addr),
        .o_sram_wmask (sram_wmask),
        .o_sram_size  (sram_size),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: word-indexed by addr[5:2]; reset loads known contents.
    assign sram_rdata = mem[sram_addr[5:2]];
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 32'hDEAD_BEEF;
            for (int i = 1; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return #1 after the edge so inputs can be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 2'b00;
        req_addr   = '0;
        req_wmask  = '0;
        req_size   = '0;
        req_wdata  = '0;
    endtask

    logic [1:0] exp_conf [0:3];
    logic [1:0] exp_bothprio;

    initial begin
`ifdef DPIC_SRAM_ARB_FIXED_PRIO_EN
        exp_conf[0] = 2'b10; exp_conf[1] = 2'b10; exp_conf[2] = 2'b10; exp_conf[3] = 2'b10;
        exp_bothprio = 2'b10;
`else
        exp_conf[0] = 2'b01; exp_conf[1] = 2'b10; exp_conf[2] = 2'b01; exp_conf[3] = 2'b10;
        exp_bothprio = 2'b01;
`endif
        idle_inputs();
        resp_ready = 2'b11;
        rst = 1'b1;
        #1;
        // Reset: requests are ignored while rst is high.
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_sram_en", 64'(sram_en), 64'h0);
        tick(); tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_rdata0", 64'(resp_rdata[0]), 64'h0);
        chk("rst_rdata1", 64'(resp_rdata[1]), 64'h0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // Conflict: both ports read for four cycles.
        req_valid   = 2'b11;
        req_addr[0] = 32'h4;
        req_addr[1] = 32'h8;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("conf_grant%0d", i), 64'(req_ready), 64'(exp_conf[i]));
            tick();
        end
        idle_inputs();
        chk("conf_rdata1", 64'(resp_rdata[1]), 64'hA000_0002);
        chk("conf_resp_valid", 64'(resp_valid), 64'h2);
        tick();
        chk("conf_drain", 64'(resp_valid), 64'h0);

        // Single read of 0x8000_0000 (model word 0 holds DEADBEEF).
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0000;
        req_size[0]  = 2'd2;
        #1;
        chk("rd_req_ready", 64'(req_ready), 64'h1);
        chk("rd_sram_en", 64'(sram_en), 64'h1);
        chk("rd_sram_addr", 64'(sram_addr), 64'h8000_0000);
        chk("rd_sram_size", 64'(sram_size), 64'h2);
        tick();
        idle_inputs();
        chk("rd_resp_valid", 64'(resp_valid), 64'h1);
        chk("rd_rdata0", 64'(resp_rdata[0]), 64'hDEAD_BEEF);
        tick();
        chk("rd_drain", 64'(resp_valid), 64'h0);

        // Back-pressure: hold port 1's response, then both request.
        resp_ready   = 2'b01;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8;
        #1;
        chk("bp_p1_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid   = 2'b11;
        req_addr[0] = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_grant%0d", i), 64'(req_ready), 64'h1);
            chk($sformatf("bp_held%0d", i), 64'(resp_valid[1]), 64'h1);
            tick();
        end
        chk("bp_rdata0", 64'(resp_rdata[0]), 64'hA000_0001);
        resp_ready = 2'b11;
        #1;
        chk("bp_release_grant", 64'(req_ready), 64'h2);
        tick();
        idle_inputs();
        chk("bp_rdata1", 64'(resp_rdata[1]), 64'hA000_0002);
        tick();
        chk("bp_drain", 64'(resp_valid), 64'h0);

        // Streaming: eight back-to-back reads on port 0.
        req_valid[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr[0] = 32'(i * 4);
            #1;
            chk($sformatf("st_accept%0d", i), 64'(req_ready), 64'h1);
            tick();
            chk($sformatf("st_valid%0d", i), 64'(resp_valid[0]), 64'h1);
            chk($sformatf("st_rdata%0d", i), 64'(resp_rdata[0]),
                (i == 0) ? 64'hDEAD_BEEF : 64'hA000_0000 + 64'(i));
        end
        idle_inputs();
        tick();
        chk("st_drain", 64'(resp_valid), 64'h0);

        // Write ack on port 1, then read back the merged word.
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h10;
        req_wmask[1] = 4'b0011;
        req_wdata[1] = 32'h1234_5678;
        req_size[1]  = 2'd2;
        #1;
        chk("wr_grant", 64'(req_ready), 64'h2);
        chk("wr_sram_wmask", 64'(sram_wmask), 64'h3);
        chk("wr_sram_wdata", 64'(sram_wdata), 64'h1234_5678);
        tick();
        req_wmask[1] = 4'b0000;
        req_wdata[1] = 32'h0;
        chk("wr_resp_valid", 64'(resp_valid), 64'h2);
        chk("wr_rdata1", 64'(resp_rdata[1]), 64'h0);
        #1;
        chk("wr_rd_grant", 64'(req_ready), 64'h2);
        chk("wr_rd_wmask", 64'(sram_wmask), 64'h0);
        tick();
        idle_inputs();
        chk("wr_rd_valid", 64'(resp_valid), 64'h2);
        chk("wr_rd_rdata1", 64'(resp_rdata[1]), 64'hA000_5678);
        tick();

        // Reset mid-flight: port 0 response held, port 1 requesting.
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h4;
        tick();
        req_valid  = 2'b10;
        resp_ready = 2'b00;
        chk("mf_pre_valid", 64'(resp_valid), 64'h1);
        rst = 1'b1;
        #1;
        chk("mf_rst_ready", 64'(req_ready), 64'h0);
        chk("mf_rst_sram_en", 64'(sram_en), 64'h0);
        tick();
        rst = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        chk("mf_resp_valid", 64'(resp_valid), 64'h0);
        chk("mf_rdata0", 64'(resp_rdata[0]), 64'h0);
        // Pointer back at port 0: a conflict now goes to port 0 (round-robin).
        req_valid = 2'b11;
        #1;
        chk("mf_ptr_grant", 64'(req_ready), 64'(exp_bothprio));
        tick();
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
